// File: rtl/collect_2x1_one_hot_seq.sv
// Purpose: merges a local port and an upstream chain port into one registered output, round-robin on contention.
// Latency: exactly one cycle from input accept to o_valid; one word per cycle sustained.
// Backpressure: o_ready is combinational and only the granted input sees it, gated by i_en and output space.
module collect_2x1_one_hot_seq #(
  parameter int DATA_WIDTH        = 32,
  parameter int IN_COMMAND_WIDTH  = 2,
  localparam int OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic [1:0]                   i_valid,
  input  logic [2*DATA_WIDTH-1:0]      i_data_bus,
  input  logic [IN_COMMAND_WIDTH-1:0]  i_cmd,
  output logic [1:0]                   o_ready,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data_bus,
  output logic [OUT_COMMAND_WIDTH-1:0] o_cmd,
  input  logic                         i_ready
);

  // 1 = local port won the most recent accepted transfer, 0 = upstream
  logic       last_grant;
  logic [1:0] grant;
  logic       space;
  logic       accept;

  // Arbitration: a lone requester wins; on contention the side that did not win last time goes next
  always_comb begin
    grant = 2'b00;
    case (i_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // The output register can take a word when empty or when it is draining this cycle
  assign space = !o_valid || i_ready;

  // Handshake: nothing is offered during reset, while disabled, or while the output is stalled
  always_comb begin
    o_ready = 2'b00;
    if (!rst && i_en && space) begin
      o_ready = grant;
    end
  end

  assign accept = |o_ready;

  // Output register and arbitration history; a drain without a refill zeroes the payload
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      o_valid    <= 1'b1;
      last_grant <= o_ready[1];
      if (o_ready[1]) begin
        o_data_bus <= i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH];
        o_cmd      <= {1'b1, {IN_COMMAND_WIDTH{1'b0}}};
      end else begin
        o_data_bus <= i_data_bus[DATA_WIDTH-1:0];
        o_cmd      <= {1'b0, i_cmd};
      end
    end else if (o_valid && i_ready) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      o_cmd      <= '0;
    end
  end

endmodule

// File: tb/tb_collect_2x1_one_hot_seq.sv
// Bench for collect_2x1_one_hot_seq: directed scenarios then randomized traffic.
// Expected values come from a word-level model of the merge node kept in this file.
// Each cycle checks o_ready before the edge and the registered outputs after it.
module tb_collect_2x1_one_hot_seq;
  localparam int DW  = 32;
  localparam int ICW = 2;
  localparam int OCW = ICW + 1;

  logic            clk;
  logic            rst;
  logic            i_en;
  logic [1:0]      i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic [ICW-1:0]  i_cmd;
  logic [1:0]      o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data_bus;
  logic [OCW-1:0]  o_cmd;
  logic            i_ready;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic           m_valid;
  logic [DW-1:0]  m_data;
  logic [OCW-1:0] m_cmd;
  int             m_last;      // index of the port that won the last transfer
  logic [1:0]     exp_rdy;

  // Random-phase producers: each holds its word until accepted
  logic           p_vld [2];
  logic [DW-1:0]  p_dat [2];
  logic [ICW-1:0] p_cmd;

  collect_2x1_one_hot_seq #(.DATA_WIDTH(DW), .IN_COMMAND_WIDTH(ICW)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .i_cmd(i_cmd), .o_ready(o_ready), .o_valid(o_valid), .o_data_bus(o_data_bus),
    .o_cmd(o_cmd), .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Which port the node should accept this cycle, from the stimulus and model state only
  function automatic logic [1:0] model_ready();
    int winner;
    if (rst || !i_en) return 2'b00;
    if (m_valid && !i_ready) return 2'b00;
    if (i_valid == 2'b00) return 2'b00;
    if (i_valid == 2'b11) winner = 1 - m_last;
    else winner = i_valid[1] ? 1 : 0;
    return 2'(1 << winner);
  endfunction

  // One clock: apply inputs, check handshake, advance model, check registered outputs
  task automatic cycle(input logic r, input logic en, input logic [1:0] v,
                       input logic [DW-1:0] loc, input logic [DW-1:0] up,
                       input logic [ICW-1:0] cmd, input logic rdy, input string tag);
    rst = r; i_en = en; i_valid = v; i_data_bus = {loc, up}; i_cmd = cmd; i_ready = rdy;
    #2;
    exp_rdy = model_ready();
    chk({tag, ".o_ready"}, 64'(o_ready), 64'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_cmd = '0; m_last = 1;
    end else if (exp_rdy != 2'b00) begin
      m_valid = 1'b1;
      if (exp_rdy[1]) begin
        m_data = loc; m_cmd = OCW'(1 << ICW); m_last = 1;
      end else begin
        m_data = up; m_cmd = OCW'(cmd); m_last = 0;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0; m_data = '0; m_cmd = '0;
    end
    #1;
    chk({tag, ".o_valid"}, 64'(o_valid), 64'(m_valid));
    chk({tag, ".o_data"},  64'(o_data_bus), 64'(m_data));
    chk({tag, ".o_cmd"},   64'(o_cmd), 64'(m_cmd));
  endtask

  localparam logic [DW-1:0] AA = 32'hAAAAAAAA;
  localparam logic [DW-1:0] BB = 32'hBBBBBBBB;

  initial begin
    m_valid = 1'b0; m_data = '0; m_cmd = '0; m_last = 1; exp_rdy = 2'b00;

    // Reset with both inputs requesting: no ready, outputs cleared
    cycle(1, 1, 2'b11, BB, AA, 2'b10, 1, "rst_a");
    cycle(1, 1, 2'b11, BB, AA, 2'b10, 1, "rst_b");
    chk("rst_cmd_zero", 64'(o_cmd), 64'(3'b000));

    // Single upstream word
    cycle(0, 1, 2'b01, BB, AA, 2'b11, 1, "up_one");
    chk("up_one_cmd", 64'(o_cmd), 64'(3'b011));
    cycle(0, 1, 2'b00, 0, 0, 2'b00, 1, "drain1");

    // Contention after reset: upstream first, then alternate with no bubble
    cycle(1, 1, 2'b00, 0, 0, 2'b00, 1, "rst2");
    for (int i = 0; i < 4; i++) cycle(0, 1, 2'b11, BB, AA, 2'b01, 1, "rr");
    cycle(0, 1, 2'b00, 0, 0, 2'b00, 1, "drain2");

    // Stall: output frozen for 3 cycles, then next word accepted on release
    cycle(0, 1, 2'b11, BB, AA, 2'b10, 1, "stall_load");
    for (int i = 0; i < 3; i++) cycle(0, 1, 2'b11, BB, AA, 2'b10, 0, "stall");
    cycle(0, 1, 2'b11, BB, AA, 2'b10, 1, "stall_rel");

    // Disabled: drain still happens, nothing accepted, then local word when enabled
    cycle(0, 0, 2'b10, BB, AA, 2'b00, 1, "en_off");
    cycle(0, 1, 2'b10, BB, AA, 2'b00, 1, "en_on");
    chk("en_on_cmd", 64'(o_cmd), 64'(3'b100));
    cycle(0, 1, 2'b00, 0, 0, 2'b00, 1, "drain3");

    // Upstream-only stream of 5 words, then contention must favour local
    for (int i = 0; i < 5; i++) cycle(0, 1, 2'b01, BB, DW'(32'h1000 + i), 2'(i), 1, "stream");
    cycle(0, 1, 2'b11, BB, AA, 2'b00, 1, "after_stream");

    // Reset while holding a stalled word discards it
    cycle(0, 1, 2'b10, BB, AA, 2'b00, 0, "pre_rst");
    cycle(1, 1, 2'b11, BB, AA, 2'b00, 0, "mid_rst");
    cycle(0, 1, 2'b11, BB, AA, 2'b01, 1, "post_rst");

    // Randomized traffic with producers that hold their word until accepted
    p_vld[0] = 1'b0; p_vld[1] = 1'b0; p_dat[0] = '0; p_dat[1] = '0; p_cmd = '0;
    for (int n = 0; n < 400; n++) begin
      logic r;
      for (int k = 0; k < 2; k++) begin
        if (!p_vld[k] && ($urandom_range(0, 3) != 0)) begin
          p_vld[k] = 1'b1;
          p_dat[k] = $urandom;
          if (k == 0) p_cmd = ICW'($urandom);
        end
      end
      r = ($urandom_range(0, 39) == 0);
      cycle(r, ($urandom_range(0, 7) != 0), {p_vld[1], p_vld[0]}, p_dat[1], p_dat[0],
            p_cmd, ($urandom_range(0, 3) != 0), "rand");
      if (exp_rdy[0]) p_vld[0] = 1'b0;
      if (exp_rdy[1]) p_vld[1] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/collect_2x1_one_hot_seq.md
COLLECT_2X1_ONE_HOT_SEQ -- requirements
Module: collect_2x1_one_hot_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width per port.
REQ-002 SHALL have parameter IN_COMMAND_WIDTH, default 2, tag width arriving on the chain input.
REQ-003 SHALL derive localparam OUT_COMMAND_WIDTH = IN_COMMAND_WIDTH+1, tag width leaving the node.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 i_en  input  1  acceptance enable.
REQ-008 i_valid  input  2  [1] = local node data valid, [0] = upstream chain data valid.
REQ-009 i_data_bus  input  2*DATA_WIDTH  [2*DW-1:DW] = local data, [DW-1:0] = upstream data.
REQ-010 i_cmd  input  IN_COMMAND_WIDTH  tag accompanying upstream data (port 0).
REQ-011 o_ready  output  2  per-input accept; bit k transfers input k when i_valid[k] && o_ready[k].
REQ-012 o_valid  output  1  output register holds valid data.
REQ-013 o_data_bus  output  DATA_WIDTH  registered merged data.
REQ-014 o_cmd  output  OUT_COMMAND_WIDTH  registered tag.
REQ-015 i_ready  input  1  downstream accept; output transfer when o_valid && i_ready.

Function
REQ-016 SHALL merge two sources into one registered output, the inverse of a one-hot distribute node: at most one input transferred per cycle.
REQ-017 SHALL prepend a source bit: local win -> o_cmd = {1'b1, {IN_COMMAND_WIDTH{1'b0}}}; upstream win -> o_cmd = {1'b0, i_cmd}.
REQ-018 SHALL hold state bit last_grant (1 = local won most recent transfer, 0 = upstream).
REQ-019 Arbitration: only one i_valid bit set -> that input granted; both set -> input not equal to last_grant granted (round-robin); none -> no grant.
REQ-020 space = !o_valid || i_ready; o_ready[k] = i_en && space && grant[k]; o_ready combinational, never both bits 1.
REQ-021 On accept of input k: o_valid<=1, o_data_bus<=selected data, o_cmd<=tag per REQ-017, last_grant<=k; latency input-to-output exactly 1 cycle.
REQ-022 last_grant SHALL update only on an accepted transfer, never on grant without space or with i_en=0.
REQ-023 Output drain with no new accept (o_valid && i_ready && no input accepted): o_valid<=0, o_data_bus<=0, o_cmd<=0 (dummy data all zero).
REQ-024 Simultaneous drain and accept in one cycle SHALL replace register contents with no bubble; full throughput 1 word/cycle.
REQ-025 o_valid && !i_ready: o_valid, o_data_bus, o_cmd held unchanged; o_ready=2'b00.
REQ-026 i_en=0: o_ready=2'b00, no accept, last_grant held; draining of a valid output register still permitted.
REQ-027 Loser of arbitration SHALL see o_ready=0 and is required to hold its data; no data dropped or duplicated.

Reset
REQ-028 rst=1 at rising edge: o_valid=0, o_data_bus=0, o_cmd=0, last_grant=1 (upstream wins first contention).
REQ-029 While rst=1: o_ready=2'b00 irrespective of other inputs.
REQ-030 Reset mid-operation SHALL discard the held output word; first post-reset accept follows REQ-019 from reset state.

Verification
REQ-031 Reset with i_valid=2'b11, i_en=1 -> o_ready=00 during reset; o_valid=0, o_data_bus=0, o_cmd=000 (IN_COMMAND_WIDTH=2) after.
REQ-032 i_valid=01, data low=32'hAAAAAAAA, i_cmd=2'b11, i_ready=1 -> o_ready=01; next cycle o_valid=1, o_data_bus=32'hAAAAAAAA, o_cmd=3'b011.
REQ-033 i_valid=11 held 4 cycles, local=32'hBBBBBBBB, upstream=32'hAAAAAAAA, i_ready=1 after reset -> outputs AAAA..,BBBB..,AAAA..,BBBB.. with o_cmd 0xx,100 alternating, o_valid continuously 1.
REQ-034 Output valid, i_ready=0 for 3 cycles, i_valid=11 -> o_ready=00, output and last_grant frozen; on i_ready=1 next word accepted same cycle.
REQ-035 i_en=0 with o_valid=1, i_ready=1, i_valid=10 -> o_ready=00; next cycle o_valid=0, o_data_bus=0; i_en=1 -> local word 32'hBBBBBBBB appears with o_cmd=3'b100.
REQ-036 Single-input stream i_valid=01 for 5 cycles, i_ready=1 -> 5 consecutive upstream words, last_grant=0, no gaps.
